// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - first-word-fall-through instruction queue between fetch and decode
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [XLEN-1:0]            pc_p4_in,
    input  logic [XLEN-1:0]            instr_in,
    input  logic                       taken_in,
    input  logic                       valid_in,
    output logic                       full,
    input  logic                       stall_in,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            pc_p4_out,
    output logic [XLEN-1:0]            instr_out,
    output logic                       taken_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [XLEN-1:0] r_pc_p4 [DEPTH];
    logic [XLEN-1:0] r_instr [DEPTH];
    logic            r_taken [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_valid;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = valid_in & ~w_full & ~flush;
    assign w_pop   = w_valid & ~stall_in & ~flush;

    // Storage is never reset; the valid-gated output muxes keep stale data hidden.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]    <= pc_in;
            r_pc_p4[r_wr_ptr] <= pc_p4_in;
            r_instr[r_wr_ptr] <= instr_in;
            r_taken[r_wr_ptr] <= taken_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign valid_out = w_valid;
    assign full      = w_full;
    assign count     = r_count;
    assign pc_out    = w_valid ? r_pc[r_rd_ptr]    : '0;
    assign pc_p4_out = w_valid ? r_pc_p4[r_rd_ptr] : '0;
    assign instr_out = w_valid ? r_instr[r_rd_ptr] : NOP;
    assign taken_out = w_valid ? r_taken[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - scoreboard testbench for instr_queue
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_p4;
        logic [31:0] instr;
        logic        taken;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] pc_p4_in = '0;
    logic [31:0] instr_in = '0;
    logic        taken_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        full;
    logic        stall_in = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] pc_p4_out;
    logic [31:0] instr_out;
    logic        taken_out;
    logic        valid_out;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;
    entry_t sb[$];

    instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .pc_in(pc_in), .pc_p4_in(pc_p4_in), .instr_in(instr_in),
        .taken_in(taken_in), .valid_in(valid_in), .full(full),
        .stall_in(stall_in), .pc_out(pc_out), .pc_p4_out(pc_p4_out),
        .instr_out(instr_out), .taken_out(taken_out),
        .valid_out(valid_out), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        valid_in = v;
        pc_in    = pc;
        pc_p4_in = pc + 32'd4;
        instr_in = pc ^ 32'hA5A5_0000;
        taken_in = pc[2];
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 64'(valid_out), 64'(0));
        check_eq({tag, "_count"}, 64'(count), 64'(0));
        check_eq({tag, "_full"},  64'(full), 64'(0));
        check_eq({tag, "_instr"}, 64'(instr_out), 64'h13);
        check_eq({tag, "_pc"},    64'(pc_out), 64'(0));
        check_eq({tag, "_pcp4"},  64'(pc_p4_out), 64'(0));
        check_eq({tag, "_taken"}, 64'(taken_out), 64'(0));
    endtask

    // One clock: check mid-cycle against the model, then advance the model at the edge.
    task automatic cycle();
        int     n;
        logic   do_pop;
        logic   do_push;
        entry_t e;
        @(negedge clk);
        n = sb.size();
        check_eq("count", 64'(count), 64'(n));
        check_eq("valid_out", 64'(valid_out), 64'(n != 0));
        check_eq("full", 64'(full), 64'(n == DEPTH));
        if (n == 0) begin
            check_eq("idle_instr", 64'(instr_out), 64'h13);
            check_eq("idle_pc", 64'(pc_out), 64'(0));
            check_eq("idle_taken", 64'(taken_out), 64'(0));
        end
        do_pop  = (n != 0) && !stall_in && !flush;
        do_push = valid_in && (n != DEPTH) && !flush;
        if (do_pop) begin
            check_eq("head_pc", 64'(pc_out), 64'(sb[0].pc));
            check_eq("head_pcp4", 64'(pc_p4_out), 64'(sb[0].pc_p4));
            check_eq("head_instr", 64'(instr_out), 64'(sb[0].instr));
            check_eq("head_taken", 64'(taken_out), 64'(sb[0].taken));
        end
        e.pc = pc_in; e.pc_p4 = pc_p4_in; e.instr = instr_in; e.taken = taken_in;
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(e);
        end
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0);
        stall_in = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        check_eq("drained", 64'(valid_out), 64'(0));
    endtask

    initial begin
        #3;
        check_idle("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Asynchronous reset mid-cycle with two entries queued
        drive(1'b1, 32'h40); cycle();
        drive(1'b1, 32'h44); stall_in = 1'b1; cycle();
        drive(1'b0, 32'h0); cycle();
        check_eq("pre_rst_count", 64'(count), 64'(2));
        #2 rst = 1'b1;
        #1;
        check_idle("async_rst");
        sb.delete();
        rst = 1'b0;
        stall_in = 1'b0;
        @(posedge clk); #1;

        // Fill and drain, with a dropped 5th push
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i * 4));
            cycle();
        end
        check_eq("fill_full", 64'(full), 64'(1));
        check_eq("fill_count", 64'(count), 64'(4));
        drain();

        // Streaming through the wrap point
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4));
            cycle();
            check_eq("stream_count_le1", 64'(count <= 3'd1), 64'(1));
        end
        drain();

        // Simultaneous push and pop at count 2
        stall_in = 1'b1;
        drive(1'b1, 32'h500); cycle();
        drive(1'b1, 32'h504); cycle();
        stall_in = 1'b0;
        drive(1'b1, 32'h508); cycle();
        check_eq("pushpop_count", 64'(count), 64'(2));
        drain();

        // Full boundary: pop at full rejects the same-cycle push
        stall_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4));
            cycle();
        end
        stall_in = 1'b0;
        drive(1'b1, 32'h610); cycle();
        check_eq("boundary_count_n", 64'(count), 64'(3));
        stall_in = 1'b1;
        drive(1'b1, 32'h610); cycle();
        check_eq("boundary_count_n1", 64'(count), 64'(4));
        drain();

        // Flush with a same-cycle push
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h700 + 32'(i * 4));
            cycle();
        end
        stall_in = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h200); cycle();
        flush = 1'b0;
        check_eq("flush_count", 64'(count), 64'(0));
        check_eq("flush_valid", 64'(valid_out), 64'(0));
        drive(1'b1, 32'h300); cycle();
        check_eq("post_flush_pc", 64'(pc_out), 64'h300);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
# instr_queue

First-word-fall-through instruction queue between `fetch_axil` and the decode stage. It captures each valid fetch result (PC, PC+4, instruction word, taken flag) and presents it to decode with a valid/stall handshake. This decouples AXI-lite fetch latency from decode back-pressure. It discards all buffered entries on a pipeline flush.

## Interface
- `DEPTH`, 4, number of entries; power of two, at least 2.
- `XLEN`, 32, width of the PC and instruction fields.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: discard all entries (branch/jump redirect).
- `pc_in` in XLEN: PC of the incoming instruction, from fetch `pc_out`.
- `pc_p4_in` in XLEN: PC+4, from fetch `pc_p4_out`.
- `instr_in` in XLEN: instruction word, from fetch `instr`.
- `taken_in` in 1: predicted-taken flag, from fetch `taken`.
- `valid_in` in 1: push request, from fetch `instr_valid`.
- `full` out 1: queue holds DEPTH entries; drives the fetch `stall`.
- `stall_in` in 1: decode cannot accept the head entry this cycle.
- `pc_out` out XLEN: head entry PC.
- `pc_p4_out` out XLEN: head entry PC+4.
- `instr_out` out XLEN: head entry instruction word.
- `taken_out` out 1: head entry taken flag.
- `valid_out` out 1: head entry present.
- `count` out $clog2(DEPTH+1): current occupancy.

## Operation
- Storage: DEPTH-entry register array with fields {pc, pc_p4, instr, taken}.
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - `count` is 0..DEPTH.
- Push: `push = valid_in & ~full & ~flush`.
  - Writes the entry at `wr_ptr`, then `wr_ptr` increments.
  - `valid_in` while full is dropped silently; fetch must honour `full`.
- Pop: `pop = valid_out & ~stall_in & ~flush`, then `rd_ptr` increments.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; both pointers advance.
- Outputs:
  - `valid_out = (count != 0)`.
  - When `valid_out` is 1, the head fields come combinationally from the array at `rd_ptr`.
  - When `valid_out` is 0, outputs are forced to `instr_out = 32'h0000_0013` (NOP), `pc_out = 0`, `pc_p4_out = 0`, `taken_out = 0`.
- `full = (count == DEPTH)`; registered-state decode only, no dependence on `stall_in`.
  - A full queue popped in cycle N accepts a push in cycle N+1, not cycle N.
- Flush:
  - On the edge with `flush = 1`: `count`, `wr_ptr` and `rd_ptr` clear to 0.
  - Any same-cycle push or pop is ignored.
  - Array contents are not cleared.
- Reset (asynchronous): pointers and `count` clear to 0.
  - Outputs then read `valid_out = 0`, `full = 0`, `count = 0`, `instr_out = 0x00000013`, `pc_out = 0`, `pc_p4_out = 0`, `taken_out = 0`.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Array registers need no reset.
- No X may reach the outputs while `valid_out = 0`.

## Timing
- Push-to-visible latency is 1 cycle: `valid_in` sampled at edge E gives `valid_out = 1` with that entry's data after E.
- There is no same-cycle bypass from an empty queue.
- Pop takes effect at the edge where `valid_out & ~stall_in`; the next entry, or empty, is presented after that edge.
- Sustained throughput is 1 entry/cycle when `0 < count < DEPTH` and both sides are active.
- `full` and `valid_out` change only on clock edges or on assertion of `rst`.
- After `flush`, `valid_out = 0` in the following cycle.
  - The first post-flush fetch result can be pushed in that following cycle.
- `stall_in` asserted with `valid_out = 0` has no effect.

## Test plan
- Reset/idle:
  - Assert `rst` mid-cycle with 2 entries queued → `valid_out` and `count` drop to 0 immediately.
  - `instr_out` reads 0x00000013; `full = 0`.
- Fill and drain:
  - Push PCs 0x00, 0x04, 0x08, 0x0C with `stall_in = 1` → `count = 4` and `full = 1`.
  - A 5th push at PC 0x10 is dropped.
  - Release `stall_in` → heads 0x00, 0x04, 0x08, 0x0C appear on consecutive cycles; then `valid_out = 0`.
- Streaming with wrap:
  - 10 back-to-back pushes (PC 0x100 step 4, `instr` = PC ^ 0xA5A5_0000) with `stall_in = 0`.
  - Required: each appears exactly once, in order, one cycle after its push; `count` never exceeds 1.
  - Pointers wrap past DEPTH without loss.
- Simultaneous push/pop at `count = 2`:
  - Push and pop in the same cycle → `count` stays 2.
  - Popped entry is the oldest; new entry lands at the tail.
- Full boundary: at `count = 4`, pop in cycle N with `valid_in = 1` → push rejected in N, accepted in N+1, `count` back to 4.
- Flush:
  - With 3 entries queued, assert `flush` together with `valid_in` (PC 0x200) and `stall_in = 0`.
  - Required next cycle: `count = 0`, `valid_out = 0`, PC 0x200 absent.
  - A push of PC 0x300 on the following cycle appears at the head one cycle later.
